// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries.
// Flush wins over push and pop; head is the registered storage slot at the read pointer.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);

    fetch_entry_t     mem_q [QDEPTH];
    fetch_entry_t     mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue registers; reset clears storage so the head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The stage only pushes into a full queue when it also pops, and only pops a valid head.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !flush && empty));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, captures icache hits into the
// fetch queue, and restarts at the execute redirect target with a full flush.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] fetch_addr,
    input  logic [31:0] icache_inst,
    input  logic        icache_valid,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    logic [63:0]  pc_q, pc_d;
    logic         enq, deq;
    logic         q_full, q_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign fetch_addr = pc_q;
    assign out_valid  = !q_empty;
    assign out_pc     = head.pc;
    assign out_inst   = head.inst;
    assign deq        = out_valid && out_ready;
    assign enq        = icache_valid && !redirect_valid && (!q_full || deq);
    assign push_entry = {pc_q, icache_inst};

    // Redirect target (word aligned) beats sequential advance; misses and full stalls hold the PC.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end else if (enq) begin
            pc_d = pc_q + 64'(INST_BYTES);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (enq),
        .push_entry (push_entry),
        .pop        (deq),
        .flush      (redirect_valid),
        .full       (q_full),
        .empty      (q_empty),
        .head       (head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus posts per-cycle expectations,
// a negedge monitor does every comparison.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          QD     = 4;

    logic        clk;
    logic        reset;
    logic [63:0] fetch_addr;
    logic [31:0] icache_inst;
    logic        icache_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_addr     (fetch_addr),
        .icache_inst    (icache_inst),
        .icache_valid   (icache_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
    );

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'hC0DE_0013;
    endfunction

    // Cache model: instruction word is a fixed function of the address.
    assign icache_inst = inst_of(fetch_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle expectations posted by the stimulus, consumed by the monitor.
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [63:0]  mpc;
    logic         chk_fa    = 1'b0;
    logic [63:0]  exp_fa    = '0;
    int           ov_chk    = -1;
    logic         chk_rst   = 1'b0;
    logic         push_exp  = 1'b0;
    logic [63:0]  push_pc   = '0;
    logic         clr_exp   = 1'b0;
    logic         chk_empty = 1'b0;
    fetch_entry_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare handshakes against the scoreboard, then apply clear/push for this cycle.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (chk_fa) chk("fetch_addr", fetch_addr, exp_fa);
            if (ov_chk >= 0) chk("out_valid", {63'b0, out_valid}, 64'(ov_chk));
            if (chk_rst) begin
                chk("reset out_pc", out_pc, 64'h0);
                chk("reset out_inst", {32'b0, out_inst}, 64'h0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h with empty scoreboard", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", {32'b0, out_inst}, {32'b0, e.inst});
                end
            end
            if (clr_exp) exp_q.delete();
            if (push_exp) exp_q.push_back({push_pc, inst_of(push_pc)});
            if (chk_empty) chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        end
    end

    // One cycle of stimulus; push = bench expects this hit to be enqueued.
    task automatic drive(input logic iv, input logic rdy, input logic rv, input logic [63:0] rpc,
                         input logic push, input int ov, input logic rst_chk);
        icache_valid   = iv;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exp_fa         = mpc;
        chk_fa         = 1'b1;
        push_exp       = push;
        push_pc        = mpc;
        ov_chk         = ov;
        chk_rst        = rst_chk;
        clr_exp        = rv;
        @(posedge clk);
        #1;
        if (rv) mpc = {rpc[63:2], 2'b00};
        else if (push) mpc = mpc + 64'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        icache_valid   = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mpc            = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        drive(0, 1, 0, '0, 0, 0, 1);

        // Streaming hits from 0x1000, one instruction per cycle.
        for (int i = 0; i < 6; i++) drive(1, 1, 0, '0, 1, (i == 0) ? 0 : 1, 0);

        // Redirect to 0x2040, then 10 miss cycles with the PC held.
        drive(0, 1, 1, 64'h2040, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, '0, 0, 0, 0);
        drive(1, 1, 0, '0, 1, 0, 0);
        drive(0, 1, 0, '0, 0, 1, 0);
        drive(0, 1, 0, '0, 0, 0, 0);

        // Fill with out_ready low: only QD entries accepted, PC stops.
        for (int i = 0; i < QD + 3; i++) drive(1, 0, 0, '0, (i < QD), (i == 0) ? 0 : 1, 0);
        // Drain with continued hits: full-with-deq keeps one enqueue per cycle.
        for (int i = 0; i < 6; i++) drive(1, 1, 0, '0, 1, 1, 0);
        for (int i = 0; i < QD; i++) drive(0, 1, 0, '0, 0, 1, 0);
        drive(0, 1, 0, '0, 0, 0, 0);

        // Three entries queued, redirect to 0x8002 with a concurrent hit and deq.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, 1, (i == 0) ? 0 : 1, 0);
        drive(1, 1, 1, 64'h8002, 0, 1, 0);
        drive(1, 1, 0, '0, 1, 0, 0);
        drive(0, 1, 0, '0, 0, 1, 0);
        drive(0, 1, 0, '0, 0, 0, 0);

        // PC wrap at the top of the address space.
        drive(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0);
        drive(1, 1, 0, '0, 1, 0, 0);
        drive(1, 1, 0, '0, 1, 1, 0);
        drive(0, 1, 0, '0, 0, 1, 0);
        drive(0, 1, 0, '0, 0, 0, 0);

        // Fill the queue, then reset during a miss.
        for (int i = 0; i < QD; i++) drive(1, 0, 0, '0, 1, (i == 0) ? 0 : 1, 0);
        reset          = 1'b1;
        icache_valid   = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        chk_fa         = 1'b0;
        ov_chk         = -1;
        chk_rst        = 1'b0;
        push_exp       = 1'b0;
        clr_exp        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mpc   = RST_PC;
        drive(0, 0, 0, '0, 0, 0, 1);

        chk_empty = 1'b1;
        drive(0, 1, 0, '0, 0, 0, 0);
        chk_empty = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
